// File: rtl/line_buffer_dp.sv
// Multi-line buffer: TAPS cascaded line RAMs (read-old-data) present the previous
// rows column-aligned with the incoming pixel, with column/row bookkeeping.
module line_buffer_dp #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 10,
    parameter int LINE_LEN = 640,
    parameter int TAPS     = 2
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  sof,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_pix,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_pix,
    output logic [TAPS*WIDTH-1:0] out_taps,
    output logic [TAPS-1:0]       taps_ok,
    output logic [DEPTH-1:0]      out_col,
    output logic                  out_eol
);

    localparam int RW = $clog2(TAPS + 1);
    localparam logic [DEPTH-1:0] LAST_COL = DEPTH'(LINE_LEN - 1);
    localparam logic [RW-1:0]    MAX_ROWS = RW'(TAPS);

    logic [WIDTH-1:0] mem [TAPS][2**DEPTH];
    logic [WIDTH-1:0] rd [TAPS];
    logic [WIDTH-1:0] wdata [TAPS];

    logic [DEPTH-1:0] col;
    logic [DEPTH-1:0] addr;
    logic [RW-1:0]    rows_seen;
    logic [RW-1:0]    rows_eff;
    logic [TAPS-1:0]  ok_now;
    logic             wrap;

    // sof restarts the frame on this very pixel rather than on the next one
    assign addr     = sof ? '0 : col;
    assign rows_eff = sof ? '0 : rows_seen;
    assign wrap     = (addr == LAST_COL);

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            rd[k]     = mem[k][addr];
            ok_now[k] = (32'(rows_eff) > k);
        end
        wdata[0] = in_pix;
        for (int k = 1; k < TAPS; k++) begin
            wdata[k] = rd[k-1];
        end
    end

    // Non-blocking writes make every RAM see the pre-write word of its neighbour.
    always_ff @(posedge clock) begin
        if (in_valid) begin
            for (int k = 0; k < TAPS; k++) begin
                mem[k][addr] <= wdata[k];
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            col       <= '0;
            rows_seen <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_taps  <= '0;
            taps_ok   <= '0;
            out_col   <= '0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_eol   <= in_valid && wrap;
            if (in_valid) begin
                out_pix <= in_pix;
                out_col <= addr;
                taps_ok <= ok_now;
                for (int k = 0; k < TAPS; k++) begin
                    out_taps[k*WIDTH +: WIDTH] <= rd[k];
                end
                if (wrap) begin
                    col       <= '0;
                    rows_seen <= (rows_eff == MAX_ROWS) ? MAX_ROWS : rows_eff + RW'(1);
                end else begin
                    col       <= addr + DEPTH'(1);
                    rows_seen <= rows_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_dp.sv
// Bench for line_buffer_dp: frame-level row/column model plus directed literal checks.
module tb_line_buffer_dp;

    logic        clock = 1'b0;
    logic        aclr;
    logic        sof;
    logic        in_valid;
    logic [7:0]  in_pix;
    logic        out_valid;
    logic [7:0]  out_pix;
    logic [15:0] out_taps;
    logic [1:0]  taps_ok;
    logic [2:0]  out_col;
    logic        out_eol;

    int checks = 0;
    int errors = 0;

    line_buffer_dp #(.WIDTH(8), .DEPTH(3), .LINE_LEN(4), .TAPS(2)) dut (
        .clock    (clock),
        .aclr     (aclr),
        .sof      (sof),
        .in_valid (in_valid),
        .in_pix   (in_pix),
        .out_valid(out_valid),
        .out_pix  (out_pix),
        .out_taps (out_taps),
        .taps_ok  (taps_ok),
        .out_col  (out_col),
        .out_eol  (out_eol)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  pix;
        logic [15:0] taps;
        logic [1:0]  ok;
        logic [2:0]  col;
        logic        eol;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    logic exp_valid;
    logic [7:0] hist [16][4];
    int m_row;
    int m_col;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pixels indexed by (frame row, column); a tap is valid when that row exists.
    always @(posedge clock or posedge aclr) begin
        if (aclr) begin
            m_row = 0;
            m_col = 0;
            exp_valid = 1'b0;
            exp_q.delete();
            last = '{pix: 8'd0, taps: 16'd0, ok: 2'd0, col: 3'd0, eol: 1'b0};
        end else begin
            exp_t e;
            exp_valid = in_valid;
            if (in_valid) begin
                if (sof) begin
                    m_row = 0;
                    m_col = 0;
                end
                e.pix  = in_pix;
                e.col  = 3'(m_col);
                e.eol  = (m_col == 3);
                e.taps = 16'd0;
                for (int k = 0; k < 2; k++) begin
                    e.ok[k] = (m_row > k);
                    if (m_row > k) e.taps[k*8 +: 8] = hist[(m_row - k - 1) % 16][m_col];
                end
                hist[m_row % 16][m_col] = in_pix;
                exp_q.push_back(e);
                m_col++;
                if (m_col == 4) begin
                    m_col = 0;
                    m_row++;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("queue_nonempty", 32'(0), 32'(1));
            end else begin
                last = exp_q.pop_front();
            end
        end
        chk("out_pix", 32'(out_pix), 32'(last.pix));
        chk("out_col", 32'(out_col), 32'(last.col));
        chk("taps_ok", 32'(taps_ok), 32'(last.ok));
        chk("out_eol", 32'(out_eol), 32'(out_valid ? last.eol : 1'b0));
        for (int k = 0; k < 2; k++) begin
            if (last.ok[k]) chk("out_taps_slice", 32'(out_taps[k*8 +: 8]), 32'(last.taps[k*8 +: 8]));
        end
    end

    task automatic push(input logic v, input logic s, input logic [7:0] p);
        in_valid = v;
        sof      = s;
        in_pix   = p;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    initial begin
        aclr = 1'b1;
        sof = 1'b0;
        in_valid = 1'b0;
        in_pix = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", 32'(out_valid), 32'(0));
        chk("reset_pix", 32'(out_pix), 32'(0));
        chk("reset_taps", 32'(out_taps), 32'(0));
        chk("reset_ok", 32'(taps_ok), 32'(0));
        chk("reset_col", 32'(out_col), 32'(0));
        chk("reset_eol", 32'(out_eol), 32'(0));
        aclr = 1'b0;
        @(posedge clock);
        #1;

        // Back-to-back frame 1..12
        for (int p = 1; p <= 12; p++) begin
            push(1'b1, p == 1, 8'(p));
            if (p == 3) chk("lit_eol_p3", 32'(out_eol), 32'(0));
            if (p == 4) chk("lit_eol_p4", 32'(out_eol), 32'(1));
            if (p == 5) begin
                chk("lit_p5_ok", 32'(taps_ok), 32'(2'b01));
                chk("lit_p5_slice0", 32'(out_taps[7:0]), 32'(1));
                chk("lit_p5_col", 32'(out_col), 32'(0));
            end
            if (p == 9) begin
                chk("lit_p9_pix", 32'(out_pix), 32'(9));
                chk("lit_p9_taps", 32'(out_taps), 32'({8'd1, 8'd5}));
                chk("lit_p9_ok", 32'(taps_ok), 32'(2'b11));
                chk("lit_p9_col", 32'(out_col), 32'(0));
            end
            if (p == 10) begin
                chk("lit_p10_old_data", 32'(out_taps[7:0]), 32'(6));
                chk("lit_p10_col", 32'(out_col), 32'(1));
            end
            if (p == 12) chk("lit_eol_p12", 32'(out_eol), 32'(1));
        end
        push(1'b0, 1'b0, 8'd0);

        // Same frame with a gap after every pixel
        for (int p = 1; p <= 12; p++) begin
            push(1'b1, p == 1, 8'(p));
            if (p == 9) chk("lit_gap_p9_taps", 32'(out_taps), 32'({8'd1, 8'd5}));
            push(1'b0, 1'b1, 8'hee);
            chk("lit_gap_valid", 32'(out_valid), 32'(0));
            chk("lit_gap_hold", 32'(out_pix), 32'(p));
        end

        // Mid-row sof on the 3rd pixel of row 1
        for (int p = 13; p <= 16; p++) push(1'b1, p == 13, 8'(p));
        push(1'b1, 1'b0, 8'd17);
        push(1'b1, 1'b0, 8'd18);
        push(1'b1, 1'b1, 8'd20);
        chk("lit_sof20_col", 32'(out_col), 32'(0));
        chk("lit_sof20_ok", 32'(taps_ok), 32'(0));
        for (int p = 21; p <= 23; p++) begin
            push(1'b1, 1'b0, 8'(p));
            chk("lit_after_sof_ok", 32'(taps_ok), 32'(0));
        end
        for (int p = 24; p <= 27; p++) begin
            push(1'b1, 1'b0, 8'(p));
            chk("lit_row1_ok", 32'(taps_ok), 32'(2'b01));
            chk("lit_row1_slice0", 32'(out_taps[7:0]), 32'(p - 4));
        end

        // aclr pulse mid-row 2
        push(1'b1, 1'b0, 8'd28);
        push(1'b1, 1'b0, 8'd29);
        #1 aclr = 1'b1;
        #1;
        chk("lit_aclr_valid", 32'(out_valid), 32'(0));
        chk("lit_aclr_pix", 32'(out_pix), 32'(0));
        chk("lit_aclr_taps", 32'(out_taps), 32'(0));
        chk("lit_aclr_ok", 32'(taps_ok), 32'(0));
        chk("lit_aclr_col", 32'(out_col), 32'(0));
        aclr = 1'b0;
        push(1'b1, 1'b0, 8'd40);
        chk("lit_post_aclr_col", 32'(out_col), 32'(0));
        chk("lit_post_aclr_ok", 32'(taps_ok), 32'(0));
        chk("lit_post_aclr_pix", 32'(out_pix), 32'(40));
        for (int p = 41; p <= 44; p++) push(1'b1, 1'b0, 8'(p));
        chk("lit_p44_ok", 32'(taps_ok), 32'(2'b01));
        chk("lit_p44_slice0", 32'(out_taps[7:0]), 32'(40));

        push(1'b0, 1'b0, 8'd0);
        push(1'b0, 1'b0, 8'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
